// File: rtl/cva6_min_pkg.sv
// Shared types and constants for the data-side bus arbiter.
// State encoding, master identifiers and the default slave latency.
package cva6_min_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_e;

    localparam logic MST_CORE   = 1'b0;
    localparam logic MST_LOADER = 1'b1;

    localparam int DEFAULT_RD_LAT = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// On a tie the master that did not win last time is selected; grant is one-hot or zero.
module rr_arb2
    import cva6_min_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = (last_grant == MST_CORE) ? 2'b10 : 2'b01;
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// Shares the single data-side slave port between the core (m0) and the loader (m1).
// One transaction in flight at a time; each grant gets exactly one rvalid RD_LAT cycles later.
module data_bus_arbiter
    import cva6_min_pkg::*;
#(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = DEFAULT_RD_LAT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            m0_req,
    input  logic            m0_we,
    input  logic [DW/8-1:0] m0_be,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    output logic [DW-1:0]   m0_rdata,
    input  logic            m1_req,
    input  logic            m1_we,
    input  logic [DW/8-1:0] m1_be,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [DW-1:0]   m1_rdata,
    output logic            s_req,
    output logic            s_we,
    output logic [DW/8-1:0] s_be,
    output logic [AW-1:0]   s_addr,
    output logic [DW-1:0]   s_wdata,
    input  logic [DW-1:0]   s_rdata,
    output logic            busy
);

    localparam int CW = $clog2(4);
    localparam logic [CW-1:0] LAT_INIT = CW'(RD_LAT - 1);

    arb_state_e    state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_grant_q, last_grant_d;
    logic [CW-1:0] lat_cnt_q, lat_cnt_d;
    logic [1:0]    arb_req;
    logic [1:0]    grant;
    logic          winner;

    // Requests are only visible to the arbiter while idle, so WAIT stalls both masters.
    assign arb_req = (state_q == IDLE) ? {m1_req, m0_req} : 2'b00;
    assign winner  = grant[1];
    assign busy    = (state_q == WAIT);

    rr_arb2 u_rr_arb2 (
        .req        (arb_req),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= MST_CORE;
            last_grant_q <= MST_LOADER;
            lat_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            lat_cnt_q    <= lat_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        lat_cnt_d    = lat_cnt_q;
        m0_gnt       = 1'b0;
        m1_gnt       = 1'b0;
        m0_rvalid    = 1'b0;
        m1_rvalid    = 1'b0;
        m0_rdata     = '0;
        m1_rdata     = '0;
        s_req        = 1'b0;
        s_we         = 1'b0;
        s_be         = '0;
        s_addr       = '0;
        s_wdata      = '0;
        case (state_q)
            IDLE: begin
                if (grant != 2'b00) begin
                    m0_gnt = grant[0];
                    m1_gnt = grant[1];
                    s_req  = 1'b1;
                    if (winner == MST_LOADER) begin
                        s_we    = m1_we;
                        s_be    = m1_be;
                        s_addr  = m1_addr;
                        s_wdata = m1_wdata;
                    end else begin
                        s_we    = m0_we;
                        s_be    = m0_be;
                        s_addr  = m0_addr;
                        s_wdata = m0_wdata;
                    end
                    owner_d      = winner;
                    last_grant_d = winner;
                    lat_cnt_d    = LAT_INIT;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                // Writes also get s_rdata back; the owner treats it as a plain ack.
                if (lat_cnt_q == '0) begin
                    if (owner_q == MST_LOADER) begin
                        m1_rvalid = 1'b1;
                        m1_rdata  = s_rdata;
                    end else begin
                        m0_rvalid = 1'b1;
                        m0_rdata  = s_rdata;
                    end
                    state_d = IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed and randomised checks of data_bus_arbiter; inputs change and outputs are sampled on the falling edge.
// One RD_LAT=2 instance for the directed steps, plus four instances (RD_LAT=1..4) for the sweep.
module tb_data_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [3:0]  m0_be, m1_be;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_we, busy;
    logic [3:0]  s_be;
    logic [31:0] s_addr, s_wdata, s_rdata;

    logic        sw_reset;
    logic        sw_m0_req, sw_m0_we, sw_m1_req, sw_m1_we;
    logic [3:0]  sw_m0_be, sw_m1_be;
    logic [31:0] sw_m0_addr, sw_m0_wdata, sw_m1_addr, sw_m1_wdata, sw_s_rdata;
    logic        sw_m0_gnt [4];
    logic        sw_m1_gnt [4];
    logic        sw_m0_rvalid [4];
    logic        sw_m1_rvalid [4];
    logic [31:0] sw_m0_rdata [4];
    logic [31:0] sw_m1_rdata [4];
    logic        sw_s_req [4];
    logic        sw_s_we [4];
    logic [3:0]  sw_s_be [4];
    logic [31:0] sw_s_addr [4];
    logic [31:0] sw_s_wdata [4];
    logic        sw_busy [4];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    data_bus_arbiter #(.AW(32), .DW(32), .RD_LAT(2)) u_dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .busy(busy)
    );

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        data_bus_arbiter #(.AW(32), .DW(32), .RD_LAT(g + 1)) u_sw (
            .clk(clk), .reset(sw_reset),
            .m0_req(sw_m0_req), .m0_we(sw_m0_we), .m0_be(sw_m0_be), .m0_addr(sw_m0_addr),
            .m0_wdata(sw_m0_wdata), .m0_gnt(sw_m0_gnt[g]), .m0_rvalid(sw_m0_rvalid[g]),
            .m0_rdata(sw_m0_rdata[g]),
            .m1_req(sw_m1_req), .m1_we(sw_m1_we), .m1_be(sw_m1_be), .m1_addr(sw_m1_addr),
            .m1_wdata(sw_m1_wdata), .m1_gnt(sw_m1_gnt[g]), .m1_rvalid(sw_m1_rvalid[g]),
            .m1_rdata(sw_m1_rdata[g]),
            .s_req(sw_s_req[g]), .s_we(sw_s_we[g]), .s_be(sw_s_be[g]), .s_addr(sw_s_addr[g]),
            .s_wdata(sw_s_wdata[g]), .s_rdata(sw_s_rdata), .busy(sw_busy[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_m0(input logic req, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata);
        m0_req = req; m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wdata;
    endtask

    task automatic set_m1(input logic req, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata);
        m1_req = req; m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = wdata;
    endtask

    task automatic apply_stimulus_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_output(input string tag, input logic eg0, input logic eg1,
                                input logic erv0, input logic erv1, input logic ebusy);
        chk({tag, ".m0_gnt"},    m0_gnt,    eg0);
        chk({tag, ".m1_gnt"},    m1_gnt,    eg1);
        chk({tag, ".m0_rvalid"}, m0_rvalid, erv0);
        chk({tag, ".m1_rvalid"}, m1_rvalid, erv1);
        chk({tag, ".busy"},      busy,      ebusy);
    endtask

    initial begin
        logic        eg0, eg1, erv0, erv1;
        logic        md_busy [4];
        logic        md_owner [4];
        logic        md_last [4];
        int          md_cnt [4];
        int          n_gnt [4];
        int          n_rv [4];
        logic [31:0] exp_addr;

        reset = 1'b1; sw_reset = 1'b1; s_rdata = '0;
        set_m0(0, 0, 4'h0, 32'h0, 32'h0);
        set_m1(0, 0, 4'h0, 32'h0, 32'h0);
        sw_m0_req = 0; sw_m0_we = 0; sw_m0_be = '0; sw_m0_addr = '0; sw_m0_wdata = '0;
        sw_m1_req = 0; sw_m1_we = 0; sw_m1_be = '0; sw_m1_addr = '0; sw_m1_wdata = '0;
        sw_s_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_output("reset", 0, 0, 0, 0, 0);
        chk("reset.s_req", s_req, 0);
        chk("reset.s_addr", s_addr, 32'h0);
        chk("reset.m0_rdata", m0_rdata, 32'h0);

        // Single m0 write: grant and slave request together, ack two cycles later.
        @(negedge clk);
        set_m0(1, 1, 4'hF, 32'h2000_0000, 32'h1);
        s_rdata = 32'h55;
        #1;
        check_output("t1_gnt", 1, 0, 0, 0, 0);
        chk("t1.s_req", s_req, 1);
        chk("t1.s_we", s_we, 1);
        chk("t1.s_be", s_be, 4'hF);
        chk("t1.s_addr", s_addr, 32'h2000_0000);
        chk("t1.s_wdata", s_wdata, 32'h1);
        @(negedge clk);
        set_m0(0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        check_output("t1_wait", 0, 0, 0, 0, 1);
        chk("t1_wait.s_req", s_req, 0);
        @(negedge clk);
        #1;
        check_output("t1_rvalid", 0, 0, 1, 0, 1);
        chk("t1.m0_rdata", m0_rdata, 32'h55);
        chk("t1.m1_rdata", m1_rdata, 32'h0);
        @(negedge clk);
        #1;
        check_output("t1_idle", 0, 0, 0, 0, 0);

        // Contested requests from reset: m0, m1, m0, m1, one grant every three cycles.
        apply_stimulus_reset();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 0) begin
                set_m0(1, 0, 4'hF, 32'h100, 32'h0);
                set_m1(1, 0, 4'hF, 32'h200, 32'h0);
            end
            #1;
            eg0  = (c % 3 == 0) && ((c / 3) % 2 == 0);
            eg1  = (c % 3 == 0) && ((c / 3) % 2 == 1);
            erv0 = (c % 3 == 2) && ((c / 3) % 2 == 0);
            erv1 = (c % 3 == 2) && ((c / 3) % 2 == 1);
            exp_addr = eg0 ? 32'h100 : (eg1 ? 32'h200 : 32'h0);
            check_output($sformatf("t2_c%0d", c), eg0, eg1, erv0, erv1, (c % 3) != 0);
            chk($sformatf("t2_c%0d.s_addr", c), s_addr, exp_addr);
        end
        @(negedge clk);
        set_m0(0, 0, 4'h0, 32'h0, 32'h0);
        set_m1(0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        check_output("t2_idle", 0, 0, 0, 0, 0);

        // m1 read returning 0xDEADBEEF.
        @(negedge clk);
        set_m1(1, 0, 4'hF, 32'h1000_0010, 32'h0);
        s_rdata = 32'h0;
        #1;
        check_output("t3_gnt", 0, 1, 0, 0, 0);
        chk("t3.s_addr", s_addr, 32'h1000_0010);
        chk("t3.s_we", s_we, 0);
        @(negedge clk);
        set_m1(0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        check_output("t3_wait", 0, 0, 0, 0, 1);
        @(negedge clk);
        s_rdata = 32'hDEAD_BEEF;
        #1;
        check_output("t3_rvalid", 0, 0, 0, 1, 1);
        chk("t3.m1_rdata", m1_rdata, 32'hDEAD_BEEF);
        chk("t3.m0_rdata", m0_rdata, 32'h0);

        // m0 arrives while an m1 transaction is outstanding and is stalled until it completes.
        @(negedge clk);
        s_rdata = 32'h0;
        set_m1(1, 1, 4'h3, 32'h300, 32'hA5);
        #1;
        check_output("t4_m1gnt", 0, 1, 0, 0, 0);
        chk("t4.s_wdata", s_wdata, 32'hA5);
        chk("t4.s_be", s_be, 4'h3);
        @(negedge clk);
        set_m1(0, 0, 4'h0, 32'h0, 32'h0);
        set_m0(1, 0, 4'hF, 32'h400, 32'h0);
        #1;
        check_output("t4_stall1", 0, 0, 0, 0, 1);
        @(negedge clk);
        #1;
        check_output("t4_stall2", 0, 0, 0, 1, 1);
        @(negedge clk);
        #1;
        check_output("t4_m0gnt", 1, 0, 0, 0, 0);
        chk("t4.s_addr", s_addr, 32'h400);
        @(negedge clk);
        set_m0(0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        check_output("t4_wait", 0, 0, 0, 0, 1);
        @(negedge clk);
        #1;
        check_output("t4_rvalid", 0, 0, 1, 0, 1);

        // Reset right after a grant drops the response and restores m0 priority.
        @(negedge clk);
        set_m0(1, 0, 4'hF, 32'h500, 32'h0);
        #1;
        check_output("t5_gnt", 1, 0, 0, 0, 0);
        @(negedge clk);
        set_m0(0, 0, 4'h0, 32'h0, 32'h0);
        reset = 1'b1;
        #1;
        check_output("t5_rst", 0, 0, 0, 0, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_output("t5_after", 0, 0, 0, 0, 0);
        @(negedge clk);
        set_m0(1, 0, 4'hF, 32'h600, 32'h0);
        set_m1(1, 0, 4'hF, 32'h700, 32'h0);
        #1;
        check_output("t5_contest", 1, 0, 0, 0, 0);
        @(negedge clk);
        set_m0(0, 0, 4'h0, 32'h0, 32'h0);
        set_m1(0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        check_output("t5_wait", 0, 0, 0, 0, 1);
        @(negedge clk);
        #1;
        check_output("t5_rvalid", 0, 0, 1, 0, 1);

        // Random traffic against all four latencies, checked cycle by cycle against a reference model.
        @(negedge clk);
        sw_reset = 1'b1;
        @(negedge clk);
        sw_reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            md_busy[k] = 0; md_owner[k] = 0; md_last[k] = 1; md_cnt[k] = 0;
            n_gnt[k] = 0; n_rv[k] = 0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            sw_m0_req   = (cyc < 390) && ($urandom_range(0, 3) != 0);
            sw_m1_req   = (cyc < 390) && ($urandom_range(0, 3) != 0);
            sw_m0_we    = 1'($urandom_range(0, 1));
            sw_m1_we    = 1'($urandom_range(0, 1));
            sw_m0_be    = 4'($urandom_range(0, 15));
            sw_m1_be    = 4'($urandom_range(0, 15));
            sw_m0_addr  = $urandom;
            sw_m1_addr  = $urandom;
            sw_m0_wdata = $urandom;
            sw_m1_wdata = $urandom;
            sw_s_rdata  = $urandom;
            #1;
            for (int k = 0; k < 4; k++) begin
                eg0 = 0; eg1 = 0; erv0 = 0; erv1 = 0;
                if (!md_busy[k]) begin
                    if (sw_m0_req && sw_m1_req) begin
                        eg0 = md_last[k];
                        eg1 = !md_last[k];
                    end else begin
                        eg0 = sw_m0_req;
                        eg1 = sw_m1_req;
                    end
                end else if (md_cnt[k] == 0) begin
                    erv0 = !md_owner[k];
                    erv1 = md_owner[k];
                end
                exp_addr = eg0 ? sw_m0_addr : (eg1 ? sw_m1_addr : 32'h0);
                chk($sformatf("sw%0d_c%0d.m0_gnt", k + 1, cyc), sw_m0_gnt[k], eg0);
                chk($sformatf("sw%0d_c%0d.m1_gnt", k + 1, cyc), sw_m1_gnt[k], eg1);
                chk($sformatf("sw%0d_c%0d.overlap", k + 1, cyc), sw_m0_gnt[k] & sw_m1_gnt[k], 0);
                chk($sformatf("sw%0d_c%0d.m0_rvalid", k + 1, cyc), sw_m0_rvalid[k], erv0);
                chk($sformatf("sw%0d_c%0d.m1_rvalid", k + 1, cyc), sw_m1_rvalid[k], erv1);
                chk($sformatf("sw%0d_c%0d.m0_rdata", k + 1, cyc), sw_m0_rdata[k], erv0 ? sw_s_rdata : 32'h0);
                chk($sformatf("sw%0d_c%0d.m1_rdata", k + 1, cyc), sw_m1_rdata[k], erv1 ? sw_s_rdata : 32'h0);
                chk($sformatf("sw%0d_c%0d.busy", k + 1, cyc), sw_busy[k], md_busy[k]);
                chk($sformatf("sw%0d_c%0d.s_req", k + 1, cyc), sw_s_req[k], eg0 | eg1);
                chk($sformatf("sw%0d_c%0d.s_addr", k + 1, cyc), sw_s_addr[k], exp_addr);
                n_gnt[k] += int'(sw_m0_gnt[k]) + int'(sw_m1_gnt[k]);
                n_rv[k]  += int'(sw_m0_rvalid[k]) + int'(sw_m1_rvalid[k]);
                if (!md_busy[k]) begin
                    if (eg0 || eg1) begin
                        md_busy[k]  = 1;
                        md_owner[k] = eg1;
                        md_last[k]  = eg1;
                        md_cnt[k]   = k;
                    end
                end else if (md_cnt[k] == 0) begin
                    md_busy[k] = 0;
                end else begin
                    md_cnt[k]--;
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("sw%0d.rvalid_per_gnt", k + 1), n_rv[k], n_gnt[k]);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
